// File: rtl/lif_pkg.sv
// Shared types, widths and the saturating narrow helper for the LIF neuron.
package lif_pkg;

    localparam int unsigned V_WIDTH = 32;

    typedef enum logic [0:0] {
        INTEGRATE,
        REFRACT
    } lif_state_e;

    // Clamp a 34-bit signed sum into the signed 32-bit range.
    function automatic logic signed [V_WIDTH-1:0] sat32(input logic signed [V_WIDTH+1:0] x);
        logic signed [V_WIDTH-1:0] r;
        if (x[V_WIDTH+1:V_WIDTH-1] == 3'b000 || x[V_WIDTH+1:V_WIDTH-1] == 3'b111) begin
            r = x[V_WIDTH-1:0];
        end else if (x[V_WIDTH+1]) begin
            r = {1'b1, {(V_WIDTH-1){1'b0}}};
        end else begin
            r = {1'b0, {(V_WIDTH-1){1'b1}}};
        end
        return r;
    endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational membrane update: leak by arithmetic shift, add input, saturate.
module lif_update
    import lif_pkg::*;
#(
    parameter int unsigned LEAK_SHIFT = 3
) (
    input  logic signed [V_WIDTH-1:0] v,
    input  logic                      in_valid,
    input  logic signed [V_WIDTH-1:0] in_current,
    output logic signed [V_WIDTH-1:0] v_next
);

    logic signed [V_WIDTH+1:0] v_ext;
    logic signed [V_WIDTH+1:0] leak;
    logic signed [V_WIDTH+1:0] cur_ext;
    logic signed [V_WIDTH+1:0] sum;

    always_comb begin
        v_ext   = {{2{v[V_WIDTH-1]}}, v};
        // >>> on a signed operand floors toward minus infinity
        leak    = v_ext >>> LEAK_SHIFT;
        cur_ext = in_valid ? {{2{in_current[V_WIDTH-1]}}, in_current} : '0;
        sum     = v_ext - leak + cur_ext;
        v_next  = sat32(sum);
    end

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: integrate/refractory FSM around lif_update.
module lif_neuron
    import lif_pkg::*;
#(
    parameter logic signed [31:0] THRESHOLD      = 32'sd100,
    parameter int unsigned        LEAK_SHIFT     = 3,
    parameter int unsigned        REFRACT_CYCLES = 4,
    parameter logic signed [31:0] V_RESET        = 32'sd0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic signed [V_WIDTH-1:0] in_current,
    output logic signed [V_WIDTH-1:0] v_mem,
    output logic                      spike,
    output logic                      refractory
);

    localparam logic [7:0] RefractLoad =
        (REFRACT_CYCLES == 0) ? 8'd0 : 8'(REFRACT_CYCLES - 1);

    lif_state_e                state_q, state_d;
    logic [7:0]                cnt_q, cnt_d;
    logic signed [V_WIDTH-1:0] v_q, v_d;
    logic                      spike_q, spike_d;
    logic signed [V_WIDTH-1:0] v_next;
    logic                      fire;

    lif_update #(
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_update (
        .v          (v_q),
        .in_valid   (in_valid),
        .in_current (in_current),
        .v_next     (v_next)
    );

    assign fire = (v_next >= THRESHOLD);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        v_d     = v_q;
        spike_d = 1'b0;
        unique case (state_q)
            INTEGRATE: begin
                if (fire) begin
                    v_d     = V_RESET;
                    spike_d = 1'b1;
                    if (REFRACT_CYCLES > 0) begin
                        state_d = REFRACT;
                        cnt_d   = RefractLoad;
                    end
                end else begin
                    v_d = v_next;
                end
            end
            REFRACT: begin
                // Inputs are dropped; membrane is parked at the reset value
                v_d = V_RESET;
                if (cnt_q == 8'd0) begin
                    state_d = INTEGRATE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = INTEGRATE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= INTEGRATE;
            cnt_q   <= 8'd0;
            v_q     <= '0;
            spike_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            v_q     <= v_d;
            spike_q <= spike_d;
        end
    end

    assign v_mem      = v_q;
    assign spike      = spike_q;
    assign refractory = (state_q == REFRACT);

endmodule
